// File: rtl/seg7_time_display.sv
// -----------------------------------------------------------------------------
// seg7_time_display
//
// Drives a 4-digit, common-anode 7-segment display with a minutes/seconds
// value in MM.SS format.
//
// Data path:
//   1. {min, sec} is resynchronised into the clk domain by two flop stages.
//   2. Once the synchronised value has been stable for two cycles and differs
//      from the last converted value, a multi-cycle double-dabble FSM
//      (IDLE -> SHIFT x6 -> COMMIT) converts sec and min to BCD in parallel.
//   3. The four digit registers load together in COMMIT, so the display can
//      never show a mix of old and new digits.
//   4. A refresh counter time-multiplexes the digits; an/seg/dp are
//      registered and change on the edge where the counter wraps.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, a zero minutes-tens digit is blanked (its anode slot is
//   still driven, so the scan timing is unchanged).
//
// Parameters:
//   REFRESH_CNT  clk cycles each digit is lit (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_CNT
//
// Ports:
//   clk    system clock, the only clock of the block
//   reset  asynchronous reset, active low
//   sec    seconds 0..63 (asynchronous to clk)
//   min    minutes 0..63 (asynchronous to clk)
//   an     digit anodes, active low, an[0] = rightmost digit
//   seg    cathodes {g,f,e,d,c,b,a}, active low
//   dp     decimal point, active low (lit only on the minutes-ones digit)
// -----------------------------------------------------------------------------
module seg7_time_display #(
    parameter int unsigned REFRESH_CNT = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } conv_state_e;

    localparam logic [6:0] SegBlank = 7'b1111111;

    // -------------------------------------------------------------------------
    // Input resynchronisation
    // -------------------------------------------------------------------------
    logic [11:0] sync1_q;
    logic [11:0] sync2_q;
    logic [11:0] sync2_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync2_prev_q <= '0;
        end else begin
            sync1_q      <= {min, sec};
            sync2_q      <= sync1_q;
            sync2_prev_q <= sync2_q;
        end
    end

    // -------------------------------------------------------------------------
    // Binary to BCD conversion (double dabble, one bit per cycle)
    // -------------------------------------------------------------------------
    conv_state_e state_q;
    logic [2:0]  shift_cnt_q;
    logic [11:0] last_conv_q;
    // {tens[3:0], ones[3:0], bin[5:0]}
    logic [13:0] sec_vec_q;
    logic [13:0] min_vec_q;
    logic [3:0]  sec_ones_q;
    logic [3:0]  sec_tens_q;
    logic [3:0]  min_ones_q;
    logic [3:0]  min_tens_q;
    logic        conv_start;

    // One double-dabble iteration: correct any BCD nibble >= 5, then shift.
    function automatic logic [13:0] dabble_step(input logic [13:0] v);
        logic [13:0] a;
        a = v;
        if (a[9:6] >= 4'd5) begin
            a[9:6] = a[9:6] + 4'd3;
        end
        if (a[13:10] >= 4'd5) begin
            a[13:10] = a[13:10] + 4'd3;
        end
        return {a[12:0], 1'b0};
    endfunction

    // Stable for two cycles and not already shown.
    assign conv_start = (state_q == StIdle) && (sync2_q == sync2_prev_q) &&
                        (sync2_q != last_conv_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_cnt_q <= '0;
            last_conv_q <= '0;
            sec_vec_q   <= '0;
            min_vec_q   <= '0;
            sec_ones_q  <= '0;
            sec_tens_q  <= '0;
            min_ones_q  <= '0;
            min_tens_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (conv_start) begin
                        sec_vec_q   <= {8'h00, sync2_q[5:0]};
                        min_vec_q   <= {8'h00, sync2_q[11:6]};
                        last_conv_q <= sync2_q;
                        shift_cnt_q <= '0;
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    sec_vec_q   <= dabble_step(sec_vec_q);
                    min_vec_q   <= dabble_step(min_vec_q);
                    shift_cnt_q <= shift_cnt_q + 3'd1;
                    if (shift_cnt_q == 3'd5) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    // All four digits update on the same edge.
                    sec_ones_q <= sec_vec_q[9:6];
                    sec_tens_q <= sec_vec_q[13:10];
                    min_ones_q <= min_vec_q[9:6];
                    min_tens_q <= min_vec_q[13:10];
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Display scan
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic             refresh_tc;
    logic [3:0]       an_q;
    logic [3:0]       an_d;
    logic [6:0]       seg_q;
    logic [6:0]       seg_d;
    logic             dp_q;
    logic             dp_d;
    logic [3:0]       digit;
    logic             blank;

    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    always_comb begin
        refresh_tc = (cnt_q == CNT_W'(REFRESH_CNT - 1));
        cnt_d      = refresh_tc ? '0 : cnt_q + CNT_W'(1);
        idx_d      = refresh_tc ? idx_q + 2'd1 : idx_q;

        // Outputs are decoded from the next index so they change on the
        // same edge the index advances.
        an_d  = 4'b1110;
        dp_d  = 1'b1;
        digit = sec_ones_q;
        blank = 1'b0;
        unique case (idx_d)
            2'd0: begin
                an_d  = 4'b1110;
                digit = sec_ones_q;
            end
            2'd1: begin
                an_d  = 4'b1101;
                digit = sec_tens_q;
            end
            2'd2: begin
                an_d  = 4'b1011;
                digit = min_ones_q;
                dp_d  = 1'b0;
            end
            2'd3: begin
                an_d  = 4'b0111;
                digit = min_tens_q;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (min_tens_q == 4'd0);
`else
                blank = 1'b0;
`endif
            end
            default: begin
                an_d  = 4'b1110;
                digit = sec_ones_q;
            end
        endcase
        seg_d = blank ? SegBlank : seg7_encode(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
